instr_loader: RTL
=================

Name: instr_loader

Overview:
- Write-side partner of the CPU's instruction fetch path.
- Receives a byte stream over a valid/ready handshake, assembles 24-bit instruction words, and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset via cpu_hold until the program is fully loaded.
- Sits between a host byte source (UART/testbench) and the instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory address width; depth = 2**ADDR_W words.
- INSTR_W, 24, instruction width; fixed at 3 bytes. Any other value is unsupported.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte-source valid.
- in_data  in  8  byte-source data.
- in_ready  out  1  loader accepts a byte when in_valid && in_ready at the rising edge.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  24  write data, layout {opcode[23:20], WA[19:16], RA1[15:12], RA2[11:8], imm[7:0]}.
- cpu_hold  out  1  drives the CPU reset; high while not DONE.
- done  out  1  level; program loaded and valid.
- err  out  1  level; load aborted.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, state=IDLE.
- Stream format: length byte N, then N instructions of 3 bytes each, MSB first: byte0 = {opcode,WA}, byte1 = {RA1,RA2}, byte2 = imm.
- in_ready=1 only in LEN, B0, B1, B2 (and CHK when CHECKSUM_EN is defined); 0 otherwise.
- in_data is ignored unless in_valid && in_ready. in_valid may drop between bytes; the FSM waits indefinitely.
- States and transitions:
  - IDLE: cpu_hold=1. On start → LEN.
  - LEN: on accept, latch N and clear word count cnt=0.
    - N=0 → DONE; no writes.
    - N > 2**ADDR_W → ERR. This is unreachable at ADDR_W=8 but must be checked for ADDR_W<8.
    - Otherwise → B0.
  - B0 / B1 / B2: on accept, shift the byte into the 24-bit assembly register; advance B0→B1→B2→WR.
  - WR: exactly one cycle. mem_we=1, mem_addr=cnt, mem_wdata=assembly register. Then cnt+1.
    - cnt+1 == N → DONE (or CHK when CHECKSUM_EN is defined).
    - Otherwise → B0.
  - DONE: done=1, cpu_hold=0. On start → LEN with done=0 and cpu_hold=1 asserted in the same cycle the state changes.
  - ERR: err=1, cpu_hold=1. On start → LEN with err cleared.
- Timing:
  - Per-word latency: last byte accepted at edge k → mem_we high during cycle k+1.
  - Minimum 4 cycles per word.
- Outputs:
  - mem_addr and mem_wdata are registered and hold their last values outside WR.
  - mem_we is never high outside WR.
- Boundary conditions:
  - cnt counter is ADDR_W+1 bits wide, so N = 2**ADDR_W completes at the last address without wrap.
  - start while in LEN, B0, B1, B2, WR or CHK is ignored.
  - reset asserted mid-load returns to the reset values immediately (asynchronously). A partially written memory is not cleared.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - A trailing checksum byte follows the last instruction, handled in state CHK.
  - Running XOR of all 3N instruction bytes, excluding the length byte. It is cleared in LEN.
  - Match → DONE; mismatch → ERR.
  - Words already written remain in memory; cpu_hold stays 1.
  - For N=0, the checksum byte is still expected and must equal 0x00.
- Undefined:
  - No CHK state and no checksum byte; WR goes directly to DONE after the last word.

Decomposition:
- Package instr_pkg:
  - INSTR_W, and field slice constants OPC_HI/LO, WA_HI/LO, RA1_HI/LO, RA2_HI/LO, IMM_HI/LO.
  - typedef enum logic [2:0] loader_state_t {IDLE, LEN, B0, B1, B2, WR, CHK, DONE, ERR} (4 bits if CHK requires it).
  - Shared with the CPU decode so the field layout has a single definition.
- Sub-module byte_assembler:
  - 24-bit shift register with shift_en and 8-bit input.
  - Includes the optional XOR accumulator.
  - FSM and counters stay in instr_loader.

Test Plan:
- Basic load:
  - Stimulus: reset low 3 cycles, start, stream 02, 1A 23 05, 2B 10 FF.
  - Response: writes addr0=0x1A2305, addr1=0x2B10FF; done=1, cpu_hold=0 one cycle after the last WR.
- Backpressure and gaps:
  - Stimulus: same stream with in_valid toggling randomly.
  - Response: identical writes; mem_we pulses exactly 2 times; no byte lost or duplicated.
- N=0:
  - Stimulus: start, byte 00.
  - Response: no mem_we; DONE in the next cycle. With checksum enabled, the 00 checksum byte is required first.
- Reset mid-load:
  - Stimulus: N=3, assert reset after 4 payload bytes.
  - Response: all outputs at reset values during reset; a following clean load of N=1 (0x112233) writes addr0 and reaches done.
- Reload from DONE:
  - Stimulus: start in DONE.
  - Response: cpu_hold rises and done falls in the same cycle; the new program overwrites from addr0.
- Checksum (INSTR_LOADER_CHECKSUM_EN defined):
  - Stimulus: N=1, bytes 1A 23 05, checksum 0x3C.
  - Response: done=1.
  - Stimulus: same with checksum 0x3D.
  - Response: err=1, cpu_hold=1, addr0 written.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction loader and CPU decode:
// instruction field layout and loader state encoding.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN adds the CHK state to the ready set.
package instr_pkg;

    localparam int INSTR_W = 24;

    localparam int OPC_HI = 23;
    localparam int OPC_LO = 20;
    localparam int WA_HI  = 19;
    localparam int WA_LO  = 16;
    localparam int RA1_HI = 15;
    localparam int RA1_LO = 12;
    localparam int RA2_HI = 11;
    localparam int RA2_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LEN  = 4'd1,
        B0   = 4'd2,
        B1   = 4'd3,
        B2   = 4'd4,
        WR   = 4'd5,
        CHK  = 4'd6,
        DONE = 4'd7,
        ERR  = 4'd8
    } loader_state_t;

    // States in which the loader takes a byte from the source.
    function automatic logic is_ready_state(input loader_state_t s);
        logic r;
        case (s)
            LEN, B0, B1, B2: r = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK:             r = 1'b1;
`endif
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Byte-to-instruction assembler. Keeps the two most recent bytes; the
// full word is presented combinationally together with the third byte so
// the loader can register it on the same edge the last byte is accepted.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN adds a running XOR of shifted bytes.
module byte_assembler
    import instr_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
`ifdef INSTR_LOADER_CHECKSUM_EN
    input  logic               acc_clr,
    output logic [7:0]         xor_o,
`endif
    output logic [INSTR_W-1:0] word_o
);

    logic [15:0] hist_q;
    logic [15:0] hist_d;

    // Next-state of the byte history.
    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d = {hist_q[7:0], byte_in};
        end else begin
            hist_d = hist_q;
        end
    end

    // Byte history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 16'h0000;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign word_o = {hist_q, byte_in};

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] acc_q;
    logic [7:0] acc_d;

    // Running XOR of instruction bytes, cleared at the start of each load.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = 8'h00;
        end else if (shift_en) begin
            acc_d = acc_q ^ byte_in;
        end else begin
            acc_d = acc_q;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign xor_o = acc_q;
`endif

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: takes a length-prefixed byte stream, writes 24-bit
// words to instruction memory from address 0 and holds the CPU in reset
// until the whole program is in place.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN expects a trailing XOR checksum byte.
module instr_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 24
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    // One extra bit so a full-depth program finishes without wrapping.
    localparam int          CNT_W = ADDR_W + 1;
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    loader_state_t      state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept_s;
    logic               shift_en_s;
    logic [INSTR_W-1:0] word_s;

    assign accept_s   = in_valid & in_ready_q;
    assign shift_en_s = accept_s & ((state_q == B0) | (state_q == B1) | (state_q == B2));

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic       acc_clr_s;
    logic [7:0] xor_s;

    assign acc_clr_s = accept_s & (state_q == LEN);
`endif

    byte_assembler u_asm (
        .clk      (CLK),
        .rst_n    (reset),
        .shift_en (shift_en_s),
        .byte_in  (in_data),
`ifdef INSTR_LOADER_CHECKSUM_EN
        .acc_clr  (acc_clr_s),
        .xor_o    (xor_s),
`endif
        .word_o   (word_s)
    );

    // Next-state logic plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                end else begin
                    state_d = state_q;
                end
            end
            LEN: begin
                if (accept_s) begin
                    n_d   = CNT_W'(in_data);
                    cnt_d = {CNT_W{1'b0}};
                    if (in_data == 8'h00) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else if ({24'h000000, in_data} > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = B0;
                    end
                end else begin
                    state_d = LEN;
                end
            end
            B0: begin
                if (accept_s) begin
                    state_d = B1;
                end else begin
                    state_d = B0;
                end
            end
            B1: begin
                if (accept_s) begin
                    state_d = B2;
                end else begin
                    state_d = B1;
                end
            end
            B2: begin
                if (accept_s) begin
                    state_d     = WR;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = word_s;
                end else begin
                    state_d = B2;
                end
            end
            WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((cnt_q + CNT_W'(1)) == n_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = B0;
                end
            end
            CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (accept_s) begin
                    if (in_data == xor_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    state_d = CHK;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = is_ready_state(state_d);
        mem_we_d   = (state_d == WR);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        cpu_hold_d = (state_d != DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= {CNT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {INSTR_W{1'b0}};
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
